// File: rtl/rename_map_table.sv
// Register alias table for integer rename: map, free list, intra-group
// bypass, x0 handling, checkpoints and commit-time freeing.
module rename_map_table #(
    parameter int RENAME_W = 4,
    parameter int COMMIT_W = 4,
    parameter int ARF_SIZE = 32,
    parameter int PRF_SIZE = 64,
    parameter int CP_DEPTH = 4,
    localparam int AW = $clog2(ARF_SIZE),
    localparam int PW = $clog2(PRF_SIZE),
    localparam int CW = $clog2(CP_DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RENAME_W-1:0]      rd_valid,
    input  logic [RENAME_W*AW-1:0]   rs1,
    input  logic [RENAME_W*AW-1:0]   rs2,
    input  logic [RENAME_W*AW-1:0]   rd,
    input  logic                     check,
    input  logic [CW-1:0]            check_idx,
    input  logic                     recover,
    input  logic [CW-1:0]            recover_idx,
    input  logic [COMMIT_W-1:0]      commit_valid,
    input  logic [COMMIT_W*PW-1:0]   commit_prf,
    output logic                     out_valid,
    output logic [RENAME_W*PW-1:0]   prs1,
    output logic [RENAME_W*PW-1:0]   prs2,
    output logic [RENAME_W*PW-1:0]   prd,
    output logic [RENAME_W*PW-1:0]   prev_prd,
    output logic [RENAME_W-1:0]      prev_valid
);

    localparam int FL_DEPTH = PRF_SIZE - ARF_SIZE;
    localparam int FW = $clog2(FL_DEPTH);

    typedef logic [FW:0] ptr_t;

    logic [PW-1:0] map_q [ARF_SIZE];
    logic [PW-1:0] fl_q [FL_DEPTH];
    logic [PW-1:0] cp_map_q [CP_DEPTH][ARF_SIZE];
    ptr_t          cp_head_q [CP_DEPTH];
    ptr_t          head_q;
    ptr_t          tail_q;

    logic [AW-1:0] rs1_a [RENAME_W];
    logic [AW-1:0] rs2_a [RENAME_W];
    logic [AW-1:0] rd_a  [RENAME_W];
    logic [FW-1:0] sidx  [RENAME_W];
    logic [PW-1:0] new_prd [RENAME_W];
    logic [RENAME_W-1:0] alloc;
    ptr_t          n_alloc;

    logic [PW-1:0] prs1_c [RENAME_W];
    logic [PW-1:0] prs2_c [RENAME_W];
    logic [PW-1:0] prd_c  [RENAME_W];
    logic [PW-1:0] prev_c [RENAME_W];
    logic [PW-1:0] map_nx [ARF_SIZE];

    logic [FW-1:0] cidx [COMMIT_W];
    ptr_t          coff;
    ptr_t          tail_nx;
    ptr_t          head_nx;
    ptr_t          count;
    logic          accept;

    // Allocating slots take consecutive free-list entries in slot order
    always_comb begin
        n_alloc = '0;
        alloc   = '0;
        for (int i = 0; i < RENAME_W; i++) begin
            rs1_a[i]   = rs1[i*AW +: AW];
            rs2_a[i]   = rs2[i*AW +: AW];
            rd_a[i]    = rd[i*AW +: AW];
            alloc[i]   = rd_valid[i] && (rd_a[i] != '0);
            sidx[i]    = head_q[FW-1:0] + n_alloc[FW-1:0];
            new_prd[i] = fl_q[sidx[i]];
            if (alloc[i]) begin
                n_alloc = n_alloc + ptr_t'(1);
            end
        end
    end

    // Older slots in the group override the table; later j wins
    always_comb begin
        for (int i = 0; i < RENAME_W; i++) begin
            prs1_c[i] = map_q[rs1_a[i]];
            prs2_c[i] = map_q[rs2_a[i]];
            prev_c[i] = map_q[rd_a[i]];
            for (int j = 0; j < RENAME_W; j++) begin
                if (j < i && alloc[j]) begin
                    if (rd_a[j] == rs1_a[i]) prs1_c[i] = new_prd[j];
                    if (rd_a[j] == rs2_a[i]) prs2_c[i] = new_prd[j];
                    if (rd_a[j] == rd_a[i])  prev_c[i] = new_prd[j];
                end
            end
            if (rs1_a[i] == '0) prs1_c[i] = '0;
            if (rs2_a[i] == '0) prs2_c[i] = '0;
            if (!alloc[i]) prev_c[i] = '0;
            prd_c[i] = alloc[i] ? new_prd[i] : '0;
        end
    end

    always_comb begin
        for (int a = 0; a < ARF_SIZE; a++) begin
            map_nx[a] = map_q[a];
        end
        for (int i = 0; i < RENAME_W; i++) begin
            if (alloc[i]) map_nx[rd_a[i]] = new_prd[i];
        end
    end

    always_comb begin
        coff = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            cidx[k] = tail_q[FW-1:0] + coff[FW-1:0];
            if (commit_valid[k]) begin
                coff = coff + ptr_t'(1);
            end
        end
        tail_nx = tail_q + coff;
    end

    assign head_nx  = head_q + n_alloc;
    assign count    = tail_q - head_q;
    assign in_ready = !recover && (count >= n_alloc);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int a = 0; a < ARF_SIZE; a++) begin
                map_q[a] <= PW'(a);
            end
            for (int c = 0; c < CP_DEPTH; c++) begin
                for (int a = 0; a < ARF_SIZE; a++) begin
                    cp_map_q[c][a] <= PW'(a);
                end
                cp_head_q[c] <= '0;
            end
            for (int f = 0; f < FL_DEPTH; f++) begin
                fl_q[f] <= PW'(ARF_SIZE + f);
            end
            head_q     <= '0;
            tail_q     <= ptr_t'(FL_DEPTH);
            out_valid  <= 1'b0;
            prs1       <= '0;
            prs2       <= '0;
            prd        <= '0;
            prev_prd   <= '0;
            prev_valid <= '0;
        end else begin
            for (int k = 0; k < COMMIT_W; k++) begin
                if (commit_valid[k]) begin
                    fl_q[cidx[k]] <= commit_prf[k*PW +: PW];
                end
            end
            tail_q    <= tail_nx;
            out_valid <= accept;
            // Tail is never rolled back: frees survive a recover
            if (recover) begin
                for (int a = 0; a < ARF_SIZE; a++) begin
                    map_q[a] <= cp_map_q[recover_idx][a];
                end
                head_q <= cp_head_q[recover_idx];
            end else if (accept) begin
                for (int a = 0; a < ARF_SIZE; a++) begin
                    map_q[a] <= map_nx[a];
                end
                head_q <= head_nx;
                if (check) begin
                    for (int a = 0; a < ARF_SIZE; a++) begin
                        cp_map_q[check_idx][a] <= map_nx[a];
                    end
                    cp_head_q[check_idx] <= head_nx;
                end
            end
            if (accept) begin
                for (int i = 0; i < RENAME_W; i++) begin
                    prs1[i*PW +: PW]     <= prs1_c[i];
                    prs2[i*PW +: PW]     <= prs2_c[i];
                    prd[i*PW +: PW]      <= prd_c[i];
                    prev_prd[i*PW +: PW] <= prev_c[i];
                end
                prev_valid <= alloc;
            end
        end
    end

endmodule
